mod_n_bcd_counter: RTL and testbench
====================================

# mod_n_bcd_counter

Synchronous two-digit BCD modulo-N counter with up/down mode, parallel load and a chainable carry/borrow output. It is the generalised successor of the fixed mod-60 seconds/minutes counter. The same block serves seconds and minutes (MODULO=60), hours (MODULO=24 or 12) and any two-digit decimal field. All stages share one clock. Stages are chained through en/carry instead of ripple clocking, so the whole clock runs off a single clk domain.

## Interface
Parameters:
- MODULO, 60, count range 0..MODULO-1; legal 2..100
- TENS_W, 3, width of tens digit; must hold (MODULO-1)/10 (3 for 60/24, 4 for 100)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- en  in  1  count enable; the carry-in from the previous stage
- up  in  1  1 = count up, 0 = count down
- load  in  1  parallel load strobe
- load_ones  in  4  BCD ones value to load
- load_tens  in  TENS_W  BCD tens value to load
- ones  out  4  ones digit, BCD
- tens  out  TENS_W  tens digit, BCD
- carry  out  1  terminal-count pulse to the next stage (carry when counting up, borrow when counting down)
- load_err  out  1  registered flag; the previous cycle's load was rejected

## Operation
- Count value V = 10*tens + ones. ones is always 0..9 and V is always < MODULO.
- Priority on each rising edge: rst low, then load, then en, then hold.
- rst low:
  - ones=0, tens=0, load_err=0.
  - carry is forced 0 while rst is low.
- Load:
  - A load is valid when load_ones≤9, load_tens≤9 and 10*load_tens+load_ones < MODULO.
  - Valid load: V takes the load value and load_err=0.
  - Invalid load: V holds and load_err=1 for one cycle.
  - en is ignored in any load cycle.
- Counting up, en=1, no load:
  - If V=MODULO-1, V becomes 0.
  - Otherwise, if ones=9, ones becomes 0 and tens increments.
  - Otherwise ones increments.
- Counting down, en=1, no load:
  - If V=0, V becomes MODULO-1.
  - Otherwise, if ones=0, ones becomes 9 and tens decrements.
  - Otherwise ones decrements.
- en=0, no load: V holds.
- load_err clears on any cycle without a rejected load.
- carry is combinational: carry = rst & en & ~load & (up ? V==MODULO-1 : V==0).
  - Stages cascade by wiring carry to the next stage's en. The full chain then advances on the same edge.
  - The chain depth adds combinational path length. Three stages must close timing at the system clock rate.
- When up changes while en=1, the new direction applies on that same edge, and carry reflects the new up value.

## Timing
- ones/tens update one clock after the qualifying edge, with no added latency.
- carry is valid in the same cycle as en. It is high for exactly the cycles where en is high at the terminal value.
  - With en held high continuously, carry is a 1-cycle pulse every MODULO cycles.
- load_err is asserted in the cycle after the rejected load, for one cycle.
- Reset mid-count returns V to 00 on that edge. Counting resumes on the first edge with rst high and en high.
- Right after reset, with en=1 and up=0, carry is 1 immediately (V=0 is terminal in down mode). This is intended behaviour.

## Structure
- Package clock_pkg:
  - BCD_MAX=4'd9
  - localparam helpers for tens width
  - typedef for a 4-bit BCD digit
- Sub-module bcd_digit instantiated twice:
  - Ports: value register, inc, dec, wrap_hi, load, tc.
  - wrap_hi is 9 for the ones digit and (MODULO-1)/10 for the tens digit.
- Top-level logic:
  - Whole-value terminal detect, because tens wrap at MODULO is not at 9.
  - Load validation.
  - carry and load_err generation.

## Test plan
- MODULO=60, up=1, en=1 from reset for 61 cycles: V steps 00..59 then 00. carry is high only in the cycle with V=59.
- MODULO=60, up=0, en=1 from reset: carry=1 at V=00, then V=59,58,…. At V=50 the next value is 49 (ones wraps 0 to 9, tens decrements).
- MODULO=24, load 23, then one en cycle: V=00 and carry pulses. Repeat with MODULO=12: 11 wraps to 00.
- Invalid loads: load ones=10 (V=12 held, load_err=1 for the next cycle only), then load 65 with MODULO=60 (same result). A valid load of 45 then gives V=45 and load_err=0.
- load=1 and en=1 at V=59, up=1: V takes the load value, carry=0 in that cycle, no increment.
- Reset and cascade:
  - rst low for one edge at V=37 with en=1: V=00.
  - Three cascaded instances (60/60/24) counting from 23:59:59 with en=1: next state 00:00:00, with all three carries high in that cycle.

Source files
------------

// File: rtl/mod_n_bcd_counter_pkg.sv
// Shared digit type and modulo helpers for the two-digit BCD modulo-N counter.
// Pure declarations; no logic, no latency, no flow control.
package mod_n_bcd_counter_pkg;

    localparam logic [3:0] BCD_MAX        = 4'd9;
    localparam int         TENS_W_DEFAULT = 3;

    typedef logic [3:0] bcd_t;

    // Tens and ones digits of the terminal value MODULO-1.
    function automatic int tens_max(input int modulo);
        return (modulo - 1) / 10;
    endfunction

    function automatic int ones_max(input int modulo);
        return (modulo - 1) % 10;
    endfunction

endpackage

// File: rtl/mod_n_bcd_counter_digit.sv
// One BCD digit register with load, increment/decrement and wrap at wrap_hi.
// Latency: 1 clk; backpressure: none, inc/dec/load strobes are acted on every edge.
module mod_n_bcd_counter_digit #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         up_i,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic [W-1:0] wrap_hi_i,
    output logic [W-1:0] value_o,
    output logic         tc_o
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (inc_i) begin
            value_d = (value_q == wrap_hi_i) ? '0 : value_q + W'(1);
        end else if (dec_i) begin
            value_d = (value_q == '0) ? wrap_hi_i : value_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    // Terminal in the current direction: at wrap_hi going up, at zero going down.
    assign tc_o    = up_i ? (value_q == wrap_hi_i) : (value_q == '0);
    assign value_o = value_q;

endmodule

// File: rtl/mod_n_bcd_counter.sv
// Two-digit BCD modulo-N up/down counter with parallel load and chainable carry/borrow.
// Latency: 1 clk for the count, carry combinational; backpressure: none, en is the only gate.
module mod_n_bcd_counter
    import mod_n_bcd_counter_pkg::*;
#(
    parameter int MODULO = 60,
    parameter int TENS_W = TENS_W_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              up_i,
    input  logic              load_i,
    input  logic [3:0]        load_ones_i,
    input  logic [TENS_W-1:0] load_tens_i,
    output logic [3:0]        ones_o,
    output logic [TENS_W-1:0] tens_o,
    output logic              carry_o,
    output logic              load_err_o
);

    localparam logic [TENS_W-1:0] TENS_MAX = TENS_W'(tens_max(MODULO));
    localparam bcd_t              ONES_MAX = 4'(ones_max(MODULO));
    localparam logic [7:0]        MOD_V    = 8'(MODULO);

    bcd_t              ones;
    logic [TENS_W-1:0] tens;
    logic              ones_tc;
    logic              tens_tc;

    logic [7:0]        load_v;
    logic              load_ok;
    logic              cnt;
    logic              term;
    logic              wrap;
    logic              dig_load;
    logic              ones_inc;
    logic              ones_dec;
    logic              tens_inc;
    logic              tens_dec;
    bcd_t              ones_ld_val;
    logic [TENS_W-1:0] tens_ld_val;

    logic              load_err_q;
    logic              load_err_d;

    assign load_v  = 8'(load_tens_i) * 8'd10 + 8'(load_ones_i);
    assign load_ok = (load_ones_i <= BCD_MAX) && (8'(load_tens_i) <= 8'(BCD_MAX)) && (load_v < MOD_V);

    // The tens digit does not wrap at 9 for MODULO=60/24/12, so the terminal value
    // is detected on the whole count rather than by chaining digit terminals.
    assign term = up_i ? (tens_tc && (ones == ONES_MAX)) : (tens_tc && ones_tc);
    assign cnt  = en_i & ~load_i;
    assign wrap = cnt & term;

    assign dig_load    = (load_i & load_ok) | wrap;
    assign ones_ld_val = load_i ? load_ones_i : (up_i ? 4'd0 : ONES_MAX);
    assign tens_ld_val = load_i ? load_tens_i : (up_i ? '0 : TENS_MAX);

    assign ones_inc = cnt & up_i & ~term;
    assign ones_dec = cnt & ~up_i & ~term;
    assign tens_inc = ones_inc & ones_tc;
    assign tens_dec = ones_dec & ones_tc;

    mod_n_bcd_counter_digit #(.W(4)) u_ones (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .up_i       (up_i),
        .inc_i      (ones_inc),
        .dec_i      (ones_dec),
        .load_i     (dig_load),
        .load_val_i (ones_ld_val),
        .wrap_hi_i  (BCD_MAX),
        .value_o    (ones),
        .tc_o       (ones_tc)
    );

    mod_n_bcd_counter_digit #(.W(TENS_W)) u_tens (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .up_i       (up_i),
        .inc_i      (tens_inc),
        .dec_i      (tens_dec),
        .load_i     (dig_load),
        .load_val_i (tens_ld_val),
        .wrap_hi_i  (TENS_MAX),
        .value_o    (tens),
        .tc_o       (tens_tc)
    );

    assign load_err_d = load_i & ~load_ok;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign ones_o     = ones;
    assign tens_o     = tens;
    assign carry_o    = rst_i & wrap;
    assign load_err_o = load_err_q;

endmodule

// File: tb/tb_mod_n_bcd_counter.sv
// Directed self-checking bench: mod-60/24/12 instances plus a 60/60/24 cascade.
module tb_mod_n_bcd_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       up;
    logic [3:0] lo;
    logic [2:0] lt;

    logic en60, ld60, en24, ld24, en12, ld12, ens, lds, ldm, ldh;

    logic [3:0] o60, o24, o12, os, om, oh;
    logic [2:0] t60, t24, t12, ts, tm, th;
    logic       c60, c24, c12, cs, cm, ch;
    logic       e60, e24, e12, es, em, eh;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mod_n_bcd_counter #(.MODULO(60)) u60 (
        .clk_i(clk), .rst_i(rst), .en_i(en60), .up_i(up), .load_i(ld60),
        .load_ones_i(lo), .load_tens_i(lt), .ones_o(o60), .tens_o(t60),
        .carry_o(c60), .load_err_o(e60));

    mod_n_bcd_counter #(.MODULO(24)) u24 (
        .clk_i(clk), .rst_i(rst), .en_i(en24), .up_i(up), .load_i(ld24),
        .load_ones_i(lo), .load_tens_i(lt), .ones_o(o24), .tens_o(t24),
        .carry_o(c24), .load_err_o(e24));

    mod_n_bcd_counter #(.MODULO(12)) u12 (
        .clk_i(clk), .rst_i(rst), .en_i(en12), .up_i(up), .load_i(ld12),
        .load_ones_i(lo), .load_tens_i(lt), .ones_o(o12), .tens_o(t12),
        .carry_o(c12), .load_err_o(e12));

    mod_n_bcd_counter #(.MODULO(60)) u_sec (
        .clk_i(clk), .rst_i(rst), .en_i(ens), .up_i(up), .load_i(lds),
        .load_ones_i(lo), .load_tens_i(lt), .ones_o(os), .tens_o(ts),
        .carry_o(cs), .load_err_o(es));

    mod_n_bcd_counter #(.MODULO(60)) u_min (
        .clk_i(clk), .rst_i(rst), .en_i(cs), .up_i(up), .load_i(ldm),
        .load_ones_i(lo), .load_tens_i(lt), .ones_o(om), .tens_o(tm),
        .carry_o(cm), .load_err_o(em));

    mod_n_bcd_counter #(.MODULO(24)) u_hr (
        .clk_i(clk), .rst_i(rst), .en_i(cm), .up_i(up), .load_i(ldh),
        .load_ones_i(lo), .load_tens_i(lt), .ones_o(oh), .tens_o(th),
        .carry_o(ch), .load_err_o(eh));

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; up = 1'b0; lo = 4'd0; lt = 3'd0;
        en60 = 1'b1; ld60 = 1'b0; en24 = 1'b0; ld24 = 1'b0; en12 = 1'b0; ld12 = 1'b0;
        ens = 1'b0; lds = 1'b0; ldm = 1'b0; ldh = 1'b0;
        #1;
        chk("rst_carry_forced", 32'(c60), 0);
        tick();
        chk("rst_v", 32'({1'b0, t60, o60}), 32'(bcd(0)));
        chk("rst_err", 32'(e60), 0);
        chk("rst_carry", 32'(c60), 0);

        // Count up 61 cycles: 00..59 then 00.
        rst = 1'b1; up = 1'b1;
        for (int i = 0; i < 61; i++) begin
            #1;
            chk("up_v", 32'({1'b0, t60, o60}), 32'(bcd(i % 60)));
            chk("up_carry", 32'(c60), 32'((i % 60) == 59));
            tick();
        end

        // Reset mid-count at 37 with en high.
        en60 = 1'b0; ld60 = 1'b1; lt = 3'd3; lo = 4'd7;
        tick();
        ld60 = 1'b0;
        chk("load37_v", 32'({1'b0, t60, o60}), 32'(bcd(37)));
        chk("load37_err", 32'(e60), 0);
        en60 = 1'b1; rst = 1'b0;
        #1;
        chk("midrst_carry", 32'(c60), 0);
        tick();
        chk("midrst_v", 32'({1'b0, t60, o60}), 32'(bcd(0)));

        // Count down: 00, 59, 58, ..., 50, 49.
        rst = 1'b1; up = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("dn_v", 32'({1'b0, t60, o60}), 32'(bcd((60 - i) % 60)));
            chk("dn_carry", 32'(c60), 32'(((60 - i) % 60) == 0));
            tick();
        end

        // Direction change at V=0 applies to carry and to the same edge.
        rst = 1'b0;
        tick();
        rst = 1'b1; up = 1'b1;
        #1;
        chk("dir_up_carry", 32'(c60), 0);
        up = 1'b0;
        #1;
        chk("dir_dn_carry", 32'(c60), 1);
        tick();
        chk("dir_dn_v", 32'({1'b0, t60, o60}), 32'(bcd(59)));

        // Load validation.
        en60 = 1'b0; ld60 = 1'b1; lt = 3'd1; lo = 4'd2;
        tick();
        chk("ld12_v", 32'({1'b0, t60, o60}), 32'(bcd(12)));
        chk("ld12_err", 32'(e60), 0);
        lo = 4'd10;
        tick();
        chk("ones10_v", 32'({1'b0, t60, o60}), 32'(bcd(12)));
        chk("ones10_err", 32'(e60), 1);
        ld60 = 1'b0;
        tick();
        chk("ones10_err_clr", 32'(e60), 0);
        chk("ones10_v_hold", 32'({1'b0, t60, o60}), 32'(bcd(12)));
        ld60 = 1'b1; lt = 3'd6; lo = 4'd5;
        tick();
        chk("ld65_v", 32'({1'b0, t60, o60}), 32'(bcd(12)));
        chk("ld65_err", 32'(e60), 1);
        ld60 = 1'b0;
        tick();
        chk("ld65_err_clr", 32'(e60), 0);
        ld60 = 1'b1; lt = 3'd6; lo = 4'd0;
        tick();
        chk("ld60_v", 32'({1'b0, t60, o60}), 32'(bcd(12)));
        chk("ld60_err", 32'(e60), 1);
        lt = 3'd4; lo = 4'd5;
        tick();
        chk("ld45_v", 32'({1'b0, t60, o60}), 32'(bcd(45)));
        chk("ld45_err", 32'(e60), 0);
        lt = 3'd5; lo = 4'd9;
        tick();
        chk("ld59_v", 32'({1'b0, t60, o60}), 32'(bcd(59)));

        // Load wins over en at the terminal value.
        ld60 = 1'b0; en60 = 1'b1; up = 1'b1;
        #1;
        chk("tc59_carry", 32'(c60), 1);
        ld60 = 1'b1; lt = 3'd0; lo = 4'd7;
        #1;
        chk("ldtc_carry", 32'(c60), 0);
        tick();
        chk("ldtc_v", 32'({1'b0, t60, o60}), 32'(bcd(7)));
        ld60 = 1'b0; en60 = 1'b0;

        // MODULO=24: 24 rejected, 23 wraps to 00 with carry.
        ld24 = 1'b1; lt = 3'd2; lo = 4'd4;
        tick();
        chk("m24_ld24_v", 32'({1'b0, t24, o24}), 32'(bcd(0)));
        chk("m24_ld24_err", 32'(e24), 1);
        lo = 4'd3;
        tick();
        chk("m24_ld23_v", 32'({1'b0, t24, o24}), 32'(bcd(23)));
        chk("m24_ld23_err", 32'(e24), 0);
        ld24 = 1'b0; en24 = 1'b1;
        #1;
        chk("m24_carry", 32'(c24), 1);
        tick();
        chk("m24_wrap_v", 32'({1'b0, t24, o24}), 32'(bcd(0)));
        chk("m24_carry_after", 32'(c24), 0);
        en24 = 1'b0;

        // MODULO=12: 11 wraps to 00 with carry.
        ld12 = 1'b1; lt = 3'd1; lo = 4'd1;
        tick();
        chk("m12_ld11_v", 32'({1'b0, t12, o12}), 32'(bcd(11)));
        ld12 = 1'b0; en12 = 1'b1;
        #1;
        chk("m12_carry", 32'(c12), 1);
        tick();
        chk("m12_wrap_v", 32'({1'b0, t12, o12}), 32'(bcd(0)));
        en12 = 1'b0;

        // Cascade 23:59:59 -> 00:00:00 on one edge.
        lds = 1'b1; ldm = 1'b1; lt = 3'd5; lo = 4'd9;
        tick();
        lds = 1'b0; ldm = 1'b0; ldh = 1'b1; lt = 3'd2; lo = 4'd3;
        tick();
        ldh = 1'b0; ens = 1'b1;
        #1;
        chk("cas_sec_pre", 32'({1'b0, ts, os}), 32'(bcd(59)));
        chk("cas_min_pre", 32'({1'b0, tm, om}), 32'(bcd(59)));
        chk("cas_hr_pre", 32'({1'b0, th, oh}), 32'(bcd(23)));
        chk("cas_sec_carry", 32'(cs), 1);
        chk("cas_min_carry", 32'(cm), 1);
        chk("cas_hr_carry", 32'(ch), 1);
        tick();
        chk("cas_sec_v", 32'({1'b0, ts, os}), 32'(bcd(0)));
        chk("cas_min_v", 32'({1'b0, tm, om}), 32'(bcd(0)));
        chk("cas_hr_v", 32'({1'b0, th, oh}), 32'(bcd(0)));
        chk("cas_sec_carry_after", 32'(cs), 0);
        ens = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
